// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 pooling datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pool_pkg;

    localparam int POOL_WIDTH = 8;
    localparam int POOL_IMG_W = 28;
    localparam int POOL_IMG_H = 28;

    // Coordinate counter width; a 1-entry range still needs one bit.
    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int POOL_COL_W = coord_w(POOL_IMG_W);
    localparam int POOL_ROW_W = coord_w(POOL_IMG_H);

    // One 2x2 window as seen by the pooling core wrapper.
    typedef struct packed {
        logic signed [POOL_WIDTH-1:0] tl;
        logic signed [POOL_WIDTH-1:0] tr;
        logic signed [POOL_WIDTH-1:0] bl;
        logic signed [POOL_WIDTH-1:0] br;
    } win_t;

endpackage

// File: rtl/pool_window_2x2_if.sv
// Pixel-in / window-out bundle between pixel source, window generator and pooling core.
// Latency: n/a (wires only).
// Backpressure: none; the window side is a pure valid strobe.
interface pool_window_2x2_if import pool_pkg::*; #(
    parameter int WIDTH = POOL_WIDTH
) ();

    logic                    din_valid;
    logic signed [WIDTH-1:0] din;
    logic                    win_valid;
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] b;
    logic signed [WIDTH-1:0] c;
    logic signed [WIDTH-1:0] d;
    logic                    frame_done;

    modport master (
        output din_valid, din,
        input  win_valid, a, b, c, d, frame_done
    );

    modport slave (
        input  din_valid, din,
        output win_valid, a, b, c, d, frame_done
    );

endinterface

// File: rtl/pool_line_buffer.sv
// Single-port row buffer holding the even (top) row of each window pair.
// Latency: read data registered, valid 1 cycle after the address is presented.
// Backpressure: none; read-first behaviour, one access per cycle.
module pool_line_buffer import pool_pkg::*; #(
    parameter int WIDTH = POOL_WIDTH,
    parameter int DEPTH = POOL_IMG_W,
    localparam int AW   = coord_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdat,
    output logic [WIDTH-1:0] rdat
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Plain RAM template without reset so it maps onto LUT or block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdat;
        end
        rdat <= mem[addr];
    end

endmodule

// File: rtl/pool_window_2x2.sv
// Raster pixel stream to non-overlapping 2x2 windows (stride 2) for the max-pool core.
// Latency: window valid 1 cycle after the edge accepting its bottom-right pixel.
// Backpressure: none; every window is presented for exactly one cycle.
module pool_window_2x2 import pool_pkg::*; #(
    parameter int WIDTH = POOL_WIDTH,
    parameter int IMG_W = POOL_IMG_W,
    parameter int IMG_H = POOL_IMG_H
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    pool_window_2x2_if.slave bus
);

    localparam int CW = coord_w(IMG_W);
    localparam int RW = coord_w(IMG_H);

    if ((IMG_W < 2) || ((IMG_W % 2) != 0)) begin : g_bad_img_w
        $error("pool_window_2x2: IMG_W must be even and >= 2");
    end
    if ((IMG_H < 2) || ((IMG_H % 2) != 0)) begin : g_bad_img_h
        $error("pool_window_2x2: IMG_H must be even and >= 2");
    end

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic             acc;
    logic             odd_row;
    logic             odd_col;
    logic             col_last;
    logic             row_last;
    logic             lb_we;
    logic [WIDTH-1:0] lb_rdat;
    logic             tl_pend;
    logic [WIDTH-1:0] tl_hold;
    logic [WIDTH-1:0] bl_hold;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] d_q;
    logic             win_vld_q;
    logic             frame_done_q;

    // A pixel coinciding with clear is dropped.
    assign acc      = bus.din_valid & ~clear;
    assign odd_row  = row[0];
    assign odd_col  = col[0];
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));

    // Even rows fill the buffer; odd rows read it at the current column.
    assign lb_we = acc & ~odd_row;

    pool_line_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (IMG_W)
    ) u_line_buffer (
        .clk  (clk),
        .we   (lb_we),
        .addr (col),
        .wdat (bus.din),
        .rdat (lb_rdat)
    );

    // Raster position, advanced per accepted pixel, wrapping into the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Left-column holds; TL arrives from the RAM the cycle after its even-column read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tl_pend <= 1'b0;
            tl_hold <= '0;
            bl_hold <= '0;
        end else if (clear) begin
            tl_pend <= 1'b0;
            tl_hold <= '0;
            bl_hold <= '0;
        end else begin
            tl_pend <= acc & odd_row & ~odd_col;
            if (tl_pend) begin
                tl_hold <= lb_rdat;
            end
            if (acc & odd_row & ~odd_col) begin
                bl_hold <= bus.din;
            end
        end
    end

    // Window register, loaded on the bottom-right pixel; TL bypasses the hold
    // when the BR pixel directly follows the BL pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            c_q          <= '0;
            d_q          <= '0;
            win_vld_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (acc & odd_row & odd_col) begin
            a_q          <= tl_pend ? lb_rdat : tl_hold;
            c_q          <= bl_hold;
            d_q          <= bus.din;
            win_vld_q    <= 1'b1;
            frame_done_q <= row_last & col_last;
        end else begin
            win_vld_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end
    end

    // TR comes straight from the RAM output register in the strobe cycle and
    // is kept here so it holds afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q <= '0;
        end else if (win_vld_q) begin
            b_q <= lb_rdat;
        end
    end

    assign bus.win_valid  = win_vld_q;
    assign bus.frame_done = frame_done_q;
    assign bus.a          = a_q;
    assign bus.b          = win_vld_q ? lb_rdat : b_q;
    assign bus.c          = c_q;
    assign bus.d          = d_q;

endmodule
